// File: rtl/cond_action_queue_if.sv
// Action-queue port bundle: dual-issue request side, flush, and the
// valid/ready drain side with occupancy and drop-count status.
interface cond_action_queue_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in0_valid;
    logic [OP_W-1:0]   in0_op;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic [OP_W-1:0]   in1_op;
    logic [DATA_W-1:0] in1_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       out_seq;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [15:0]       drop_cnt;

    // Producer/consumer side: drives requests, flush and out_ready.
    modport master (
        output in0_valid, in0_op, in0_data, in1_valid, in1_op, in1_data,
        output flush, out_ready,
        input  out_valid, out_op, out_data, out_seq, count, full, empty, drop_cnt
    );

    // Queue side.
    modport slave (
        input  in0_valid, in0_op, in0_data, in1_valid, in1_op, in1_data,
        input  flush, out_ready,
        output out_valid, out_op, out_data, out_seq, count, full, empty, drop_cnt
    );
endinterface

// File: rtl/cond_action_queue.sv
// Conditional action queue: accepts up to two action requests per cycle in
// issue order (in0 before in1), stamps each with a 16-bit sequence number and
// drains one entry per cycle. Requests that do not fit are counted in a
// saturating drop counter. Flush empties the queue but keeps seq and drops.
module cond_action_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cond_action_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OP_W-1:0]   op_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [15:0]       seq_mem_r  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [15:0]       seq_r;
    logic [15:0]       drop_cnt_r;
    logic              full_r;
    logic              empty_r;

    logic              pop_s;
    logic [CNT_W-1:0]  free_s;
    logic [1:0]        req_s;
    logic [1:0]        acc_s;
    logic [1:0]        drop_s;
    logic [16:0]       drop_sum_s;
    logic [OP_W-1:0]   slot0_op_s;
    logic [DATA_W-1:0] slot0_data_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [15:0]       seq_next_s;
    logic [15:0]       drop_next_s;

    // Acceptance, drop and next-state arithmetic for one cycle.
    always_comb begin
        pop_s        = !empty_r && bus.out_ready;
        // A same-cycle pop frees a slot for this cycle's pushes.
        free_s       = CNT_W'(DEPTH) - count_r + {{(CNT_W-1){1'b0}}, pop_s};
        req_s        = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
        acc_s        = 2'd0;
        drop_s       = 2'd0;
        slot0_op_s   = bus.in1_op;
        slot0_data_s = bus.in1_data;
        count_next_s = count_r;
        seq_next_s   = seq_r;
        drop_next_s  = drop_cnt_r;

        if (free_s >= CNT_W'(2)) begin
            acc_s = req_s;
        end else if (free_s == CNT_W'(1)) begin
            acc_s = (req_s != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            acc_s = 2'd0;
        end
        drop_s = req_s - acc_s;

        // The first written slot is in0 when present, otherwise a lone in1.
        if (bus.in0_valid) begin
            slot0_op_s   = bus.in0_op;
            slot0_data_s = bus.in0_data;
        end else begin
            slot0_op_s   = bus.in1_op;
            slot0_data_s = bus.in1_data;
        end

        drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drop_s};

        // Flush discards everything this cycle; discarded requests are not drops.
        if (bus.flush) begin
            count_next_s = {CNT_W{1'b0}};
            seq_next_s   = seq_r;
            drop_next_s  = drop_cnt_r;
        end else begin
            count_next_s = count_r + {{(CNT_W-2){1'b0}}, acc_s}
                         - {{(CNT_W-1){1'b0}}, pop_s};
            seq_next_s   = seq_r + {14'd0, acc_s};
            drop_next_s  = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

    // Pointers, occupancy, sequence and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            seq_r      <= 16'd0;
            drop_cnt_r <= 16'd0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            if (bus.flush) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
                wr_ptr_r <= wr_ptr_r + PTR_W'(acc_s);
            end
            count_r    <= count_next_s;
            seq_r      <= seq_next_s;
            drop_cnt_r <= drop_next_s;
            full_r     <= (count_next_s == CNT_W'(DEPTH));
            empty_r    <= (count_next_s == {CNT_W{1'b0}});
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_r[i]   <= {OP_W{1'b0}};
                data_mem_r[i] <= {DATA_W{1'b0}};
                seq_mem_r[i]  <= 16'd0;
            end
        end else if (!bus.flush) begin
            if (acc_s != 2'd0) begin
                op_mem_r[wr_ptr_r]   <= slot0_op_s;
                data_mem_r[wr_ptr_r] <= slot0_data_s;
                seq_mem_r[wr_ptr_r]  <= seq_r;
            end
            if (acc_s == 2'd2) begin
                op_mem_r[wr_ptr_r + PTR_W'(1)]   <= bus.in1_op;
                data_mem_r[wr_ptr_r + PTR_W'(1)] <= bus.in1_data;
                seq_mem_r[wr_ptr_r + PTR_W'(1)]  <= seq_r + 16'd1;
            end
        end
    end

    assign bus.out_valid = !empty_r;
    assign bus.out_op    = op_mem_r[rd_ptr_r];
    assign bus.out_data  = data_mem_r[rd_ptr_r];
    assign bus.out_seq   = seq_mem_r[rd_ptr_r];
    assign bus.count     = count_r;
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_cond_action_queue.sv
// Bench for cond_action_queue: a table of per-cycle vectors with expected
// occupancy/drop counts, a reference queue scoreboard checking every pop,
// plus hand sequences for sequence wrap and asynchronous reset.
module tb_cond_action_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic        v0;
        logic [1:0]  o0;
        logic [31:0] d0;
        logic        v1;
        logic [1:0]  o1;
        logic [31:0] d1;
        logic        fl;
        logic        rdy;
        int          exp_count;
        int          exp_drop;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [15:0] seq;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ent_t        sb_q[$];
    logic [15:0] m_seq;
    logic [15:0] m_drop;

    cond_action_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .OP_W(2)) bus ();

    cond_action_queue #(.DEPTH(DEPTH), .DATA_W(32), .OP_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input logic fl, input logic rdy,
                                input int ec, input int ed);
        vec_t v;
        v.v0 = v0; v.o0 = d0[1:0]; v.d0 = d0;
        v.v1 = v1; v.o1 = d1[2:1]; v.d1 = d1;
        v.fl = fl; v.rdy = rdy; v.exp_count = ec; v.exp_drop = ed;
        return v;
    endfunction

    // One clock cycle; called at posedge+1, returns at posedge+1.
    task automatic step(input vec_t v);
        logic pop;
        int   free;
        ent_t e;
        bus.in0_valid = v.v0; bus.in0_op = v.o0; bus.in0_data = v.d0;
        bus.in1_valid = v.v1; bus.in1_op = v.o1; bus.in1_data = v.d1;
        bus.flush = v.fl; bus.out_ready = v.rdy;
        #1;
        pop = (sb_q.size() > 0) && v.rdy;
        chk("pre_out_valid", {63'd0, bus.out_valid}, {63'd0, sb_q.size() > 0});
        if (sb_q.size() > 0) begin
            chk("head_op",   {62'd0, bus.out_op},   {62'd0, sb_q[0].op});
            chk("head_data", {32'd0, bus.out_data}, {32'd0, sb_q[0].data});
            chk("head_seq",  {48'd0, bus.out_seq},  {48'd0, sb_q[0].seq});
        end
        @(posedge clk);
        if (v.fl) begin
            sb_q.delete();
        end else begin
            free = DEPTH - sb_q.size() + (pop ? 1 : 0);
            if (pop) void'(sb_q.pop_front());
            if (v.v0) begin
                if (free > 0) begin
                    e.op = v.o0; e.data = v.d0; e.seq = m_seq;
                    sb_q.push_back(e); m_seq = m_seq + 16'd1; free--;
                end else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            if (v.v1) begin
                if (free > 0) begin
                    e.op = v.o1; e.data = v.d1; e.seq = m_seq;
                    sb_q.push_back(e); m_seq = m_seq + 16'd1; free--;
                end else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        #1;
        chk("count",     {60'd0, bus.count},     64'(sb_q.size()));
        chk("full",      {63'd0, bus.full},      {63'd0, sb_q.size() == DEPTH});
        chk("empty",     {63'd0, bus.empty},     {63'd0, sb_q.size() == 0});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, sb_q.size() > 0});
        chk("drop_cnt",  {48'd0, bus.drop_cnt},  {48'd0, m_drop});
    endtask

    initial begin
        vec_t tbl[15];
        checks = 0; failures = 0;
        m_seq = 16'd0; m_drop = 16'd0;
        bus.in0_valid = 1'b0; bus.in0_op = 2'd0; bus.in0_data = 32'd0;
        bus.in1_valid = 1'b0; bus.in1_op = 2'd0; bus.in1_data = 32'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_count",     {60'd0, bus.count},     64'd0);
        chk("rst_empty",     {63'd0, bus.empty},     64'd1);
        chk("rst_full",      {63'd0, bus.full},      64'd0);
        chk("rst_drop",      {48'd0, bus.drop_cnt},  64'd0);
        chk("rst_seq",       {48'd0, bus.out_seq},   64'd0);
        chk("rst_data",      {32'd0, bus.out_data},  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //            v0  d0      v1  d1      fl  rdy cnt drop
        tbl[0]  = mk(1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 1'b0, 1, 0);
        tbl[1]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 0, 0);
        tbl[2]  = mk(1'b1, 32'hA,  1'b1, 32'hB,  1'b0, 1'b1, 2, 0);
        tbl[3]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 1, 0);
        tbl[4]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 0, 0);
        tbl[5]  = mk(1'b1, 32'h21, 1'b1, 32'h22, 1'b0, 1'b0, 2, 0);
        tbl[6]  = mk(1'b1, 32'h23, 1'b1, 32'h24, 1'b0, 1'b0, 4, 0);
        tbl[7]  = mk(1'b1, 32'h25, 1'b1, 32'h26, 1'b0, 1'b0, 6, 0);
        tbl[8]  = mk(1'b0, 32'h0,  1'b1, 32'h27, 1'b0, 1'b0, 7, 0);
        tbl[9]  = mk(1'b1, 32'h28, 1'b1, 32'h29, 1'b0, 1'b0, 8, 1);
        tbl[10] = mk(1'b1, 32'h2A, 1'b1, 32'h2B, 1'b0, 1'b0, 8, 3);
        tbl[11] = mk(1'b1, 32'h2C, 1'b0, 32'h0,  1'b0, 1'b1, 8, 3);
        tbl[12] = mk(1'b1, 32'h2D, 1'b1, 32'h2E, 1'b1, 1'b1, 0, 3);
        tbl[13] = mk(1'b1, 32'h2F, 1'b0, 32'h0,  1'b0, 1'b0, 1, 3);
        tbl[14] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 0, 3);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i]);
            chk($sformatf("tbl%0d_count", i), {60'd0, bus.count}, 64'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_drop", i),  {48'd0, bus.drop_cnt}, 64'(tbl[i].exp_drop));
        end

        // Advance seq to just below 0xFFFF: four dual pushes then a flush.
        while ((16'hFFFF - m_seq) >= 16'd8) begin
            for (int k = 0; k < 4; k++)
                step(mk(1'b1, 32'h100 + k, 1'b1, 32'h200 + k, 1'b0, 1'b0, -1, -1));
            step(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, -1, -1));
        end
        while (m_seq != 16'hFFFF)
            step(mk(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, -1, -1));
        step(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, -1, -1));
        step(mk(1'b1, 32'h55, 1'b1, 32'h66, 1'b0, 1'b0, -1, -1));
        chk("wrap_seq_hi", {48'd0, bus.out_seq}, 64'h0000_0000_0000_FFFF);
        step(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, -1, -1));
        chk("wrap_seq_lo", {48'd0, bus.out_seq}, 64'd0);
        chk("wrap_data_lo", {32'd0, bus.out_data}, 64'h66);
        step(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, -1, -1));

        // Asynchronous reset in the middle of a drain.
        step(mk(1'b1, 32'h71, 1'b1, 32'h72, 1'b0, 1'b0, -1, -1));
        step(mk(1'b1, 32'h73, 1'b1, 32'h74, 1'b0, 1'b1, -1, -1));
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_count",     {60'd0, bus.count},     64'd0);
        chk("arst_empty",     {63'd0, bus.empty},     64'd1);
        chk("arst_drop",      {48'd0, bus.drop_cnt},  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        m_seq = 16'd0; m_drop = 16'd0;
        step(mk(1'b1, 32'h81, 1'b0, 32'h0, 1'b0, 1'b0, -1, -1));
        chk("post_rst_seq", {48'd0, bus.out_seq}, 64'd0);
        step(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, -1, -1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
